// File: rtl/cv32e40p_mult_nmr_voter_pkg.sv
// Shared types for the N-modular-redundancy multiplier voter.
// Contents:
//   lane_state_e     - health of one multiplier replica
//   nmr_mode_e       - redundancy level derived from the number of active lanes
//   mode_from_count  - maps an active-lane count onto nmr_mode_e
package cv32e40p_mult_nmr_voter_pkg;

  typedef enum logic [1:0] {
    LANE_HEALTHY = 2'd0,
    LANE_SUSPECT = 2'd1,
    LANE_FAILED  = 2'd2
  } lane_state_e;

  typedef enum logic [1:0] {
    NMR_FULL    = 2'd0,
    NMR_DMR     = 2'd1,
    NMR_SIMPLEX = 2'd2,
    NMR_NONE    = 2'd3
  } nmr_mode_e;

  // Three or more lanes still give a true majority vote; two can only detect,
  // one can only pass through, zero means nothing is trustworthy.
  function automatic nmr_mode_e mode_from_count(input int unsigned count);
    nmr_mode_e mode;
    if (count >= 3)      mode = NMR_FULL;
    else if (count == 2) mode = NMR_DMR;
    else if (count == 1) mode = NMR_SIMPLEX;
    else                 mode = NMR_NONE;
    return mode;
  endfunction

endpackage

// File: rtl/cv32e40p_nmr_lane_health.sv
// Health tracker for one multiplier replica.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   cmp_en    - a compare with a valid majority winner happens this cycle
//   agree     - this lane's bundle matches the winner's bundle
//   reenable  - pulse that returns a FAILED lane to HEALTHY
//   active    - lane is not FAILED and takes part in voting
module cv32e40p_nmr_lane_health
  import cv32e40p_mult_nmr_voter_pkg::*;
#(
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned CLEAR_CNT  = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cmp_en,
  input  logic agree,
  input  logic reenable,
  output logic active
);

  // One extra bit so the incremented counters can be compared against the
  // thresholds without wrapping.
  localparam int unsigned CW1 = CNT_W + 1;
  localparam logic [CW1-1:0] THRESH_W = CW1'(ERR_THRESH);
  localparam logic [CW1-1:0] CLEAR_W  = CW1'(CLEAR_CNT);

  lane_state_e state_q, state_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [CNT_W-1:0] ok_q, ok_d;
  logic [CW1-1:0] mis_inc;
  logic [CW1-1:0] ok_inc;

  // State and counter registers; a reset puts the lane back in service.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LANE_HEALTHY;
      mis_q   <= '0;
      ok_q    <= '0;
    end else begin
      state_q <= state_d;
      mis_q   <= mis_d;
      ok_q    <= ok_d;
    end
  end

  // Next-state logic. A FAILED lane is never compared, so only the re-enable
  // pulse can move it; the other states only move on a qualified compare.
  always_comb begin
    state_d = state_q;
    mis_d   = mis_q;
    ok_d    = ok_q;
    mis_inc = {1'b0, mis_q} + CW1'(1);
    ok_inc  = {1'b0, ok_q} + CW1'(1);

    unique case (state_q)
      LANE_HEALTHY: begin
        if (cmp_en && !agree) begin
          mis_d   = CNT_W'(1);
          ok_d    = '0;
          state_d = (THRESH_W <= CW1'(1)) ? LANE_FAILED : LANE_SUSPECT;
        end
      end
      LANE_SUSPECT: begin
        if (cmp_en) begin
          if (!agree) begin
            mis_d = mis_inc[CNT_W] ? '1 : mis_inc[CNT_W-1:0];
            ok_d  = '0;
            if (mis_inc >= THRESH_W) state_d = LANE_FAILED;
          end else if (ok_inc == CLEAR_W) begin
            state_d = LANE_HEALTHY;
            mis_d   = '0;
            ok_d    = '0;
          end else begin
            ok_d = ok_inc[CNT_W] ? '1 : ok_inc[CNT_W-1:0];
          end
        end
      end
      LANE_FAILED: begin
        if (reenable) begin
          state_d = LANE_HEALTHY;
          mis_d   = '0;
          ok_d    = '0;
        end
      end
      default: begin
        state_d = LANE_HEALTHY;
        mis_d   = '0;
        ok_d    = '0;
      end
    endcase
  end

  assign active = (state_q != LANE_FAILED);

endmodule

// File: rtl/cv32e40p_mult_nmr_voter.sv
// N-modular-redundancy voter for replicated cv32e40p_mult instances.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   cmp_valid_i           - compare strobe; lane health only moves on it
//   lane_result_i         - packed replica results, lane i at [i*WIDTH +: WIDTH]
//   lane_multicycle_i, lane_mulh_active_i, lane_ready_i - replica status flags
//   lane_reenable_i       - per-lane pulse returning a FAILED lane to service
//   result_o, multicycle_o, mulh_active_o, ready_o - voted bundle (combinational)
//   lane_active_o         - lanes not FAILED
//   mode_o                - redundancy level (nmr_mode_e encoding)
//   err_corrected_o       - registered pulse: majority found, an active lane disagreed
//   err_uncorrectable_o   - registered pulse: no majority among active lanes
//   total_err_cnt_o       - saturating count of error pulses
module cv32e40p_mult_nmr_voter
  import cv32e40p_mult_nmr_voter_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 3,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned CLEAR_CNT  = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmp_valid_i,
  input  logic [NUM_LANES*WIDTH-1:0] lane_result_i,
  input  logic [NUM_LANES-1:0]       lane_multicycle_i,
  input  logic [NUM_LANES-1:0]       lane_mulh_active_i,
  input  logic [NUM_LANES-1:0]       lane_ready_i,
  input  logic [NUM_LANES-1:0]       lane_reenable_i,
  output logic [WIDTH-1:0]           result_o,
  output logic                       multicycle_o,
  output logic                       mulh_active_o,
  output logic                       ready_o,
  output logic [NUM_LANES-1:0]       lane_active_o,
  output logic [1:0]                 mode_o,
  output logic                       err_corrected_o,
  output logic                       err_uncorrectable_o,
  output logic [CNT_W-1:0]           total_err_cnt_o
);

  localparam int unsigned BW   = WIDTH + 3;
  localparam int unsigned ACW  = $clog2(NUM_LANES + 1);
  localparam int unsigned IDXW = $clog2(NUM_LANES);

  logic [BW-1:0]        bundle [NUM_LANES];
  logic [ACW-1:0]       agree_cnt [NUM_LANES];
  logic [ACW-1:0]       active_count;
  logic [NUM_LANES-1:0] active;
  logic [NUM_LANES-1:0] lane_agree;
  logic                 win_found;
  logic                 fallback_found;
  logic [IDXW-1:0]      win_idx;
  logic [IDXW-1:0]      sel_idx;
  logic                 check_en;
  logic                 lane_cmp_en;
  logic                 corr_d, unc_d;
  logic                 corr_q, unc_q;
  logic [CNT_W-1:0]     total_q;

  // Flags ride along with the result so that two lanes only count as agreeing
  // when every field of the bundle matches.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      bundle[i] = {lane_result_i[i*WIDTH +: WIDTH], lane_multicycle_i[i],
                   lane_mulh_active_i[i], lane_ready_i[i]};
    end
  end

  // Vote: count active lanes, count matching peers for each lane, pick the
  // lowest-index strict majority. Without one, fall back to the lowest active
  // lane, and to lane 0 when nothing is active.
  always_comb begin
    active_count   = '0;
    win_found      = 1'b0;
    win_idx        = '0;
    fallback_found = 1'b0;
    sel_idx        = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      active_count = active_count + ACW'(active[i]);
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      agree_cnt[i] = '0;
      for (int j = 0; j < NUM_LANES; j++) begin
        if (active[j] && (bundle[j] == bundle[i])) agree_cnt[i] = agree_cnt[i] + ACW'(1);
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!win_found && active[i] && ({agree_cnt[i], 1'b0} > {1'b0, active_count})) begin
        win_found = 1'b1;
        win_idx   = IDXW'(i);
      end
    end
    if (win_found) begin
      sel_idx = win_idx;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!fallback_found && active[i]) begin
          fallback_found = 1'b1;
          sel_idx        = IDXW'(i);
        end
      end
    end
  end

  // Blame is only assigned when a winner exists and at least two lanes are
  // active; a split vote reports an error but leaves every lane untouched.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_agree[i] = (bundle[i] == bundle[win_idx]);
    end
    check_en    = cmp_valid_i && (active_count >= ACW'(2));
    lane_cmp_en = check_en && win_found;
    corr_d      = lane_cmp_en && (|(active & ~lane_agree));
    unc_d       = check_en && !win_found;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cv32e40p_nmr_lane_health #(
      .ERR_THRESH (ERR_THRESH),
      .CLEAR_CNT  (CLEAR_CNT),
      .CNT_W      (CNT_W)
    ) u_health (
      .clk      (clk),
      .rst      (rst),
      .cmp_en   (lane_cmp_en),
      .agree    (lane_agree[g]),
      .reenable (lane_reenable_i[g]),
      .active   (active[g])
    );
  end

  // Error pulses appear the cycle after the strobe; the running total
  // saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_q  <= 1'b0;
      unc_q   <= 1'b0;
      total_q <= '0;
    end else begin
      corr_q <= corr_d;
      unc_q  <= unc_d;
      if ((corr_d || unc_d) && (total_q != '1)) total_q <= total_q + CNT_W'(1);
    end
  end

  assign result_o            = bundle[sel_idx][BW-1:3];
  assign multicycle_o        = bundle[sel_idx][2];
  assign mulh_active_o       = bundle[sel_idx][1];
  assign ready_o             = bundle[sel_idx][0];
  assign lane_active_o       = active;
  assign mode_o              = mode_from_count(32'(active_count));
  assign err_corrected_o     = corr_q;
  assign err_uncorrectable_o = unc_q;
  assign total_err_cnt_o     = total_q;

endmodule

// File: tb/tb_cv32e40p_mult_nmr_voter.sv
// Self-checking bench for cv32e40p_mult_nmr_voter (3 lanes, 32-bit results).
// Directed scenarios followed by a randomized phase, all checked against a
// behavioural model of the voting and lane-health rules.
module tb_cv32e40p_mult_nmr_voter;

  localparam int N   = 3;
  localparam int W   = 32;
  localparam int THR = 4;
  localparam int CLR = 16;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmp_valid;
  logic [N*W-1:0] lane_result;
  logic [N-1:0]   lane_mc, lane_mh, lane_rdy, lane_reen;
  logic [W-1:0]   result;
  logic           multicycle, mulh_active, ready;
  logic [N-1:0]   lane_active;
  logic [1:0]     mode;
  logic           err_corr, err_unc;
  logic [CW-1:0]  total_cnt;

  cv32e40p_mult_nmr_voter #(
    .NUM_LANES (N), .WIDTH (W), .ERR_THRESH (THR), .CLEAR_CNT (CLR), .CNT_W (CW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmp_valid_i         (cmp_valid),
    .lane_result_i       (lane_result),
    .lane_multicycle_i   (lane_mc),
    .lane_mulh_active_i  (lane_mh),
    .lane_ready_i        (lane_rdy),
    .lane_reenable_i     (lane_reen),
    .result_o            (result),
    .multicycle_o        (multicycle),
    .mulh_active_o       (mulh_active),
    .ready_o             (ready),
    .lane_active_o       (lane_active),
    .mode_o              (mode),
    .err_corrected_o     (err_corr),
    .err_uncorrectable_o (err_unc),
    .total_err_cnt_o     (total_cnt)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Stimulus for the next cycle
  logic [W-1:0] s_res [N];
  bit s_mc [N], s_mh [N], s_rd [N], s_reen [N];
  bit s_valid, s_rst;

  // Model state: 0 healthy, 1 suspect, 2 failed
  int st [N], mis [N], okc [N];
  int m_corr, m_unc, m_total;

  function automatic bit same(input int a, input int b);
    return (s_res[a] == s_res[b]) && (s_mc[a] == s_mc[b]) &&
           (s_mh[a] == s_mh[b]) && (s_rd[a] == s_rd[b]);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      st[i] = 0; mis[i] = 0; okc[i] = 0;
    end
    m_corr = 0; m_unc = 0; m_total = 0;
  endtask

  task automatic setAll(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) begin
      s_res[i] = base; s_mc[i] = 0; s_mh[i] = 0; s_rd[i] = 1; s_reen[i] = 0;
    end
    s_valid = 1; s_rst = 0;
  endtask

  // Drives one cycle, checks mid-cycle, advances the model at the clock edge.
  task automatic applyStimulus(input string tag, input bit do_check);
    int act, win, sel;
    int agr [N];
    int old [N];
    bit corr, unc;
    logic [N-1:0] exp_act;

    rst       = s_rst;
    cmp_valid = s_valid;
    for (int i = 0; i < N; i++) begin
      lane_result[i*W +: W] = s_res[i];
      lane_mc[i]   = s_mc[i];
      lane_mh[i]   = s_mh[i];
      lane_rdy[i]  = s_rd[i];
      lane_reen[i] = s_reen[i];
    end

    act = 0;
    for (int i = 0; i < N; i++) if (st[i] != 2) act++;
    win = -1;
    for (int i = 0; i < N; i++) begin
      agr[i] = 0;
      for (int j = 0; j < N; j++) if (st[j] != 2 && same(i, j)) agr[i]++;
      if (win < 0 && st[i] != 2 && 2 * agr[i] > act) win = i;
    end
    sel = win;
    if (sel < 0) begin
      sel = 0;
      for (int i = N - 1; i >= 0; i--) if (st[i] != 2) sel = i;
    end
    for (int i = 0; i < N; i++) exp_act[i] = (st[i] != 2);

    #4;
    if (do_check) begin
      checkOutput({tag, ".result"}, result, s_res[sel]);
      checkOutput({tag, ".multicycle"}, 32'(multicycle), 32'(s_mc[sel]));
      checkOutput({tag, ".mulh_active"}, 32'(mulh_active), 32'(s_mh[sel]));
      checkOutput({tag, ".ready"}, 32'(ready), 32'(s_rd[sel]));
      checkOutput({tag, ".lane_active"}, 32'(lane_active), 32'(exp_act));
      checkOutput({tag, ".mode"}, 32'(mode), (act >= 3) ? 0 : (act == 2) ? 1 : (act == 1) ? 2 : 3);
      checkOutput({tag, ".err_corrected"}, 32'(err_corr), m_corr);
      checkOutput({tag, ".err_uncorrectable"}, 32'(err_unc), m_unc);
      checkOutput({tag, ".total_err_cnt"}, 32'(total_cnt), m_total);
    end

    @(posedge clk);
    if (s_rst) begin
      modelReset();
    end else begin
      old  = st;
      corr = 0;
      unc  = 0;
      if (s_valid && act >= 2) begin
        if (win < 0) begin
          unc = 1;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (old[i] == 2) continue;
            if (!same(i, win)) begin
              corr   = 1;
              mis[i] = (mis[i] + 1 > 255) ? 255 : mis[i] + 1;
              okc[i] = 0;
              st[i]  = (mis[i] >= THR) ? 2 : 1;
            end else if (old[i] == 1) begin
              okc[i]++;
              if (okc[i] == CLR) begin
                st[i] = 0; mis[i] = 0; okc[i] = 0;
              end
            end
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (old[i] == 2 && s_reen[i]) begin
          st[i] = 0; mis[i] = 0; okc[i] = 0;
        end
      end
      m_corr = corr;
      m_unc  = unc;
      if ((corr || unc) && m_total < 255) m_total++;
    end
    #1;
  endtask

  initial begin
    logic [W-1:0] base;
    bit bmc, bmh, brd;

    // Establish a known state before any check
    setAll(32'h0000_1234);
    s_rst = 1;
    applyStimulus("init", 0);
    applyStimulus("reset", 1);
    s_rst = 0;

    // All lanes agree
    for (int k = 0; k < 20; k++) applyStimulus("all_equal", 1);

    // Single corrected error on lane 1
    s_res[1] = 32'hDEAD_BEEF;
    applyStimulus("lane1_bad", 1);
    setAll(32'h0000_1234);
    applyStimulus("lane1_pulse", 1);

    // Lane 2 disagrees until it fails
    for (int k = 0; k < THR; k++) begin
      setAll(32'h0000_1234);
      s_res[2] = 32'h5555_0000 + k;
      applyStimulus("lane2_bad", 1);
    end
    setAll(32'h0000_1234);
    s_valid = 0;
    applyStimulus("lane2_failed", 1);
    checkOutput("lane2_failed.active_direct", 32'(lane_active), 32'h3);

    // Reset mid-operation restores full redundancy
    s_rst = 1;
    applyStimulus("mid_reset", 1);
    s_rst = 0;
    s_valid = 0;
    applyStimulus("after_reset", 1);
    checkOutput("after_reset.total_direct", 32'(total_cnt), 0);

    // Rebuild: lane 1 suspect, lane 2 failed
    setAll(32'h0000_1234);
    s_res[1] = 32'h0BAD_0001;
    applyStimulus("rb_lane1", 1);
    for (int k = 0; k < THR; k++) begin
      setAll(32'h0000_1234);
      s_res[2] = 32'h7777_0000;
      applyStimulus("rb_lane2", 1);
    end

    // DMR split: lane 0 passes through, nobody blamed
    setAll(32'h0000_4321);
    s_res[1] = 32'h0000_0999;
    applyStimulus("dmr_split", 1);
    setAll(32'h0000_4321);
    s_mh[1] = 1;
    applyStimulus("dmr_split_flag", 1);

    // Lane 1 recovers, then lane 2 is re-enabled
    for (int k = 0; k < CLR; k++) begin
      setAll(32'h0000_1234 + k);
      applyStimulus("lane1_recover", 1);
    end
    setAll(32'h0000_1234);
    s_reen[2] = 1;
    s_reen[0] = 1;
    applyStimulus("reenable", 1);
    setAll(32'h0000_1234);
    applyStimulus("reenabled", 1);

    // Randomized phase with a reset in the middle
    for (int k = 0; k < 400; k++) begin
      base = $urandom;
      bmc  = 1'($urandom_range(0, 1));
      bmh  = 1'($urandom_range(0, 1));
      brd  = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        s_res[i] = base; s_mc[i] = bmc; s_mh[i] = bmh; s_rd[i] = brd;
        if ($urandom_range(0, 4) == 0) begin
          case ($urandom_range(0, 3))
            0: s_res[i] = base ^ (32'h1 << $urandom_range(0, 1));
            1: s_mc[i]  = ~bmc;
            2: s_mh[i]  = ~bmh;
            default: s_rd[i] = ~brd;
          endcase
        end
        s_reen[i] = ($urandom_range(0, 15) == 0);
      end
      s_valid = ($urandom_range(0, 3) != 0);
      s_rst   = (k == 200);
      applyStimulus("random", 1);
    end

    setAll(32'h0000_0000);
    s_valid = 0;
    applyStimulus("final", 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
